// File: rtl/ws2812b_frame_driver.sv
// ws2812b_frame_driver
//   Output stage of the Game of Life matrix. Fetches one frame of 24-bit GRB
//   pixels through a 1-cycle-latency read port and streams each pixel MSB first
//   onto the WS2812B one-wire line. Every bit takes exactly BIT_CYC clocks. After
//   the last bit the line is held low for RESET_CYC clocks so the LEDs latch the
//   frame. Then frame_done pulses for one cycle.
//
//   The next pixel is prefetched inside bit 0 of the current pixel. Because of
//   this, the bit stream has no gap between pixels.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset (aborts a frame immediately)
//   start        1-cycle frame request, ignored while busy
//   bright_shift per-channel right shift, sampled at start
//                (present only when WS2812B_BRIGHTNESS_EN is defined)
//   pixel_rd     frame-buffer read strobe
//   pixel_addr   frame-buffer read address, valid with pixel_rd, held between reads
//   pixel_data   GRB word {G,R,B}, valid the cycle after pixel_rd
//   busy         high from the fetch cycle through the last latch cycle
//   frame_done   1-cycle pulse after the latch period
//   dout         WS2812B serial data
//
// Configuration macro: WS2812B_BRIGHTNESS_EN
//   Defining this macro adds the bright_shift input. Each 8-bit channel is then
//   shifted right by the sampled amount when the pixel is loaded. Timing is the
//   same in both builds.
module ws2812b_frame_driver #(
  parameter int NUM_PIXELS = 64,
  parameter int ADDR_W     = 6,
  parameter int BIT_CYC    = 15,
  parameter int T0H_CYC    = 4,
  parameter int T1H_CYC    = 8,
  parameter int RESET_CYC  = 3600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef WS2812B_BRIGHTNESS_EN
  input  logic [2:0]        bright_shift,
`endif
  output logic              pixel_rd,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [23:0]       pixel_data,
  output logic              busy,
  output logic              frame_done,
  output logic              dout
);

  localparam int CNT_W = $clog2(BIT_CYC);
  localparam int LAT_W = $clog2(RESET_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIT_CYC - 1);
  // Prefetch strobe is registered, so it is launched one cycle before BIT_CYC-2.
  localparam logic [CNT_W-1:0]  CNT_PREF = CNT_W'(BIT_CYC - 3);
  localparam logic [CNT_W-1:0]  T0H_C    = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0]  T1H_C    = CNT_W'(T1H_CYC);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RESET_CYC - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NUM_PIXELS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [4:0]        bit_idx_r;
  logic [ADDR_W-1:0] pix_idx_r;
  logic [LAT_W-1:0]  lat_cnt_r;
  logic [23:0]       shift_r;
  logic              pixel_rd_r;
  logic [ADDR_W-1:0] pixel_addr_r;
  logic              busy_r;
  logic              frame_done_r;
  logic              dout_r;

  logic [CNT_W-1:0]  next_cnt_s;
  logic [CNT_W-1:0]  high_len_s;
  logic [23:0]       load_word_s;

  assign next_cnt_s = cnt_r + CNT_W'(1);
  assign high_len_s = shift_r[23] ? T1H_C : T0H_C;

`ifdef WS2812B_BRIGHTNESS_EN
  logic [2:0] shift_amt_r;
  assign load_word_s = {pixel_data[23:16] >> shift_amt_r,
                        pixel_data[15:8]  >> shift_amt_r,
                        pixel_data[7:0]   >> shift_amt_r};

  // Brightness is sampled with an accepted start and held for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_amt_r <= 3'd0;
    end else if (state_r == S_IDLE && start) begin
      shift_amt_r <= bright_shift;
    end else begin
      shift_amt_r <= shift_amt_r;
    end
  end
`else
  assign load_word_s = pixel_data;
`endif

  // Frame sequencer: fetch, per-bit waveform timing, prefetch, and latch hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 5'd0;
      pix_idx_r    <= '0;
      lat_cnt_r    <= '0;
      shift_r      <= 24'd0;
      pixel_rd_r   <= 1'b0;
      pixel_addr_r <= '0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      dout_r       <= 1'b0;
    end else begin
      pixel_rd_r   <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r      <= S_FETCH;
            pixel_rd_r   <= 1'b1;
            pixel_addr_r <= '0;
            pix_idx_r    <= '0;
            busy_r       <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_FETCH: begin
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          state_r   <= S_SEND;
          shift_r   <= load_word_s;
          bit_idx_r <= 5'd23;
          cnt_r     <= '0;
          // Both bit types start high, so dout rises before the bit is inspected.
          dout_r    <= 1'b1;
        end
        S_SEND: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (bit_idx_r == 5'd0) begin
              if (pix_idx_r == PIX_LAST) begin
                state_r   <= S_LATCH;
                lat_cnt_r <= '0;
                dout_r    <= 1'b0;
              end else begin
                // The prefetched word is on pixel_data in this cycle.
                shift_r   <= load_word_s;
                bit_idx_r <= 5'd23;
                pix_idx_r <= pix_idx_r + ADDR_W'(1);
                dout_r    <= 1'b1;
              end
            end else begin
              shift_r   <= {shift_r[22:0], 1'b0};
              bit_idx_r <= bit_idx_r - 5'd1;
              dout_r    <= 1'b1;
            end
          end else begin
            cnt_r  <= next_cnt_s;
            dout_r <= (next_cnt_s < high_len_s);
            if (bit_idx_r == 5'd0 && cnt_r == CNT_PREF && pix_idx_r != PIX_LAST) begin
              pixel_rd_r   <= 1'b1;
              pixel_addr_r <= pix_idx_r + ADDR_W'(1);
            end else begin
              pixel_rd_r <= 1'b0;
            end
          end
        end
        S_LATCH: begin
          dout_r <= 1'b0;
          if (lat_cnt_r == LAT_LAST) begin
            state_r      <= S_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_W'(1);
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          dout_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_rd   = pixel_rd_r;
  assign pixel_addr = pixel_addr_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign dout       = dout_r;

endmodule

// File: tb/tb_ws2812b_frame_driver.sv
// Testbench for ws2812b_frame_driver.
//   Records every output cycle by cycle over three frames:
//     1. a full frame with a stray start at cycle 500;
//     2. a frame started back-to-back, then aborted by reset;
//     3. a restarted frame.
//   The recorded trace is checked against three things: hand-derived vectors,
//   an arithmetic reference model, and an independent pulse-width decoder.
module tb_ws2812b_frame_driver;

  localparam int NUM_PIXELS = 64;
  localparam int ADDR_W     = 6;
  localparam int BIT_CYC    = 15;
  localparam int T0H_CYC    = 4;
  localparam int T1H_CYC    = 8;
  localparam int RESET_CYC  = 3600;
  localparam int PIX_CYC    = 24 * BIT_CYC;
  localparam int FRAME_LEN  = 3 + NUM_PIXELS * PIX_CYC + RESET_CYC; // frame_done cycle
  localparam int B2         = FRAME_LEN;      // frame 2 accepted at frame_done cycle
  localparam int RST_T      = B2 + 2003;      // pixel 5, bit 10 of frame 2
  localparam int B3         = RST_T + 10;     // frame 3 start
  localparam int LOGN       = B3 + 800;

`ifdef WS2812B_BRIGHTNESS_EN
  localparam int BS3 = 2;
  logic [2:0] bright_shift;
`else
  localparam int BS3 = 0;
`endif

  logic clk, rst_n, start, pixel_rd, busy, frame_done, dout;
  logic [ADDR_W-1:0] pixel_addr;
  logic [23:0]       pixel_data;

  logic [23:0]       fb [NUM_PIXELS];
  logic              lg_d [0:LOGN];
  logic              lg_b [0:LOGN];
  logic              lg_r [0:LOGN];
  logic              lg_f [0:LOGN];
  logic [ADDR_W-1:0] lg_a [0:LOGN];

  int n_checks;
  int n_pass;

  typedef struct {
    int                cyc;
    logic [3:0]        dbrf;   // {dout, busy, pixel_rd, frame_done}
    logic              chk_a;
    logic [ADDR_W-1:0] a;
  } vec_t;
  vec_t vecs[$];

  ws2812b_frame_driver #(
    .NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W), .BIT_CYC(BIT_CYC),
    .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .RESET_CYC(RESET_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef WS2812B_BRIGHTNESS_EN
    .bright_shift(bright_shift),
`endif
    .pixel_rd(pixel_rd),
    .pixel_addr(pixel_addr),
    .pixel_data(pixel_data),
    .busy(busy),
    .frame_done(frame_done),
    .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer with one-cycle read latency.
  always @(posedge clk) begin
    if (pixel_rd) pixel_data <= fb[pixel_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] shaped(input logic [23:0] w, input int s);
    return {w[23:16] >> s, w[15:8] >> s, w[7:0] >> s};
  endfunction

  // Expected outputs r cycles after the edge that accepted start.
  task automatic ref_at(input int r, input int s, output logic d, output logic b,
                        output logic rd, output logic dn, output logic [ADDR_W-1:0] a);
    int k, p, bi, c;
    logic [23:0] w;
    d  = 1'b0;
    rd = (r == 1);
    a  = '0;
    b  = (r >= 1) && (r < FRAME_LEN);
    dn = (r == FRAME_LEN);
    if (r >= 3 && r < 3 + NUM_PIXELS * PIX_CYC) begin
      k  = r - 3;
      p  = k / PIX_CYC;
      bi = 23 - (k % PIX_CYC) / BIT_CYC;
      c  = k % BIT_CYC;
      w  = shaped(fb[p], s);
      d  = (c < (w[bi] ? T1H_CYC : T0H_CYC));
      if (bi == 0 && c == BIT_CYC - 2 && p < NUM_PIXELS - 1) begin
        rd = 1'b1;
        a  = ADDR_W'(p + 1);
      end
    end
  endtask

  task automatic check_range(input string name, input int base, input int r_lo,
                             input int r_hi, input int s);
    int bad, first;
    logic d, b, rd, dn;
    logic [ADDR_W-1:0] a;
    bad = 0;
    first = -1;
    for (int r = r_lo; r <= r_hi; r++) begin
      ref_at(r, s, d, b, rd, dn, a);
      if (lg_d[base+r] !== d || lg_b[base+r] !== b || lg_r[base+r] !== rd ||
          lg_f[base+r] !== dn || (rd && lg_a[base+r] !== a)) begin
        bad++;
        if (first < 0) first = base + r;
      end
    end
    check($sformatf("%s (first bad cycle %0d)", name, first), bad, 0);
  endtask

  function automatic void add_vec(input int cyc, input logic [3:0] dbrf,
                                  input logic chk_a, input logic [ADDR_W-1:0] a);
    vec_t v;
    v.cyc = cyc; v.dbrf = dbrf; v.chk_a = chk_a; v.a = a;
    vecs.push_back(v);
  endfunction

  initial begin
    int rises[$];
    int gap_bad, w_bad, hand_bad, word_bad, rd_cnt, idle_bad, w, exp_w;
    logic [23:0] word;

    n_checks = 0;
    n_pass   = 0;

    // Hand-derived checkpoints for fb[0]=800001, fb[1]=000000.
    add_vec(1,        4'b0110, 1'b1, 6'd0);
    add_vec(2,        4'b0100, 1'b1, 6'd0);
    add_vec(3,        4'b1100, 1'b0, 6'd0);
    add_vec(10,       4'b1100, 1'b0, 6'd0);
    add_vec(11,       4'b0100, 1'b0, 6'd0);
    add_vec(18,       4'b1100, 1'b0, 6'd0);
    add_vec(21,       4'b1100, 1'b0, 6'd0);
    add_vec(22,       4'b0100, 1'b0, 6'd0);
    add_vec(355,      4'b1100, 1'b0, 6'd0);
    add_vec(356,      4'b0100, 1'b0, 6'd0);
    add_vec(360,      4'b0100, 1'b1, 6'd0);
    add_vec(361,      4'b0110, 1'b1, 6'd1);
    add_vec(362,      4'b0100, 1'b1, 6'd1);
    add_vec(363,      4'b1100, 1'b0, 6'd0);
    add_vec(366,      4'b1100, 1'b0, 6'd0);
    add_vec(367,      4'b0100, 1'b0, 6'd0);
    add_vec(500,      4'b1100, 1'b0, 6'd0);
    add_vec(501,      4'b1100, 1'b0, 6'd0);
    add_vec(23042,    4'b0100, 1'b1, 6'd63);
    add_vec(23043,    4'b0100, 1'b0, 6'd0);
    add_vec(26642,    4'b0100, 1'b0, 6'd0);
    add_vec(26643,    4'b0001, 1'b0, 6'd0);
    add_vec(26644,    4'b0110, 1'b1, 6'd0);
    add_vec(RST_T+1,  4'b0000, 1'b1, 6'd0);
    add_vec(B3+1,     4'b0110, 1'b1, 6'd0);
    add_vec(B3+3,     4'b1100, 1'b0, 6'd0);

    fb[0] = 24'h800001;
    fb[1] = 24'h000000;
    for (int p = 2; p < NUM_PIXELS; p++) fb[p] = 24'($urandom());

    // Reset held with start asserted.
    rst_n = 1'b0;
    start = 1'b1;
`ifdef WS2812B_BRIGHTNESS_EN
    bright_shift = 3'd0;
`endif
    repeat (2) begin
      @(negedge clk);
      check("reset outputs", {dout, busy, pixel_rd, frame_done}, 4'b0000);
    end
    check("reset addr", pixel_addr, 6'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle outputs", {dout, busy, pixel_rd, frame_done}, 4'b0000);

    // Edge 0 samples this start.
    start = 1'b1;
    for (int t = 1; t <= LOGN; t++) begin
      @(negedge clk);
      lg_d[t] = dout;
      lg_b[t] = busy;
      lg_r[t] = pixel_rd;
      lg_f[t] = frame_done;
      lg_a[t] = pixel_addr;
      start = (t == 500) || (t == FRAME_LEN - 1) || (t == FRAME_LEN) || (t == B3);
      rst_n = !((t == RST_T) || (t == RST_T + 1));
`ifdef WS2812B_BRIGHTNESS_EN
      bright_shift = (t >= RST_T) ? 3'd2 : 3'd0;
`endif
    end
    start = 1'b0;

    foreach (vecs[i]) begin
      check($sformatf("vec%0d@%0d outputs", i, vecs[i].cyc),
            {lg_d[vecs[i].cyc], lg_b[vecs[i].cyc], lg_r[vecs[i].cyc], lg_f[vecs[i].cyc]},
            vecs[i].dbrf);
      if (vecs[i].chk_a)
        check($sformatf("vec%0d@%0d addr", i, vecs[i].cyc), lg_a[vecs[i].cyc], vecs[i].a);
    end

    check_range("frame1 model", 0, 1, FRAME_LEN, 0);
    check_range("frame2 model", B2, 1, RST_T - B2, 0);
    check_range("frame3 model", B3, 1, 800, BS3);

    rd_cnt = 0;
    for (int t = 1; t <= FRAME_LEN; t++) if (lg_r[t] === 1'b1) rd_cnt++;
    check("frame1 read count", rd_cnt, NUM_PIXELS);

    idle_bad = 0;
    for (int t = RST_T + 1; t <= B3; t++)
      if ({lg_d[t], lg_b[t], lg_r[t], lg_f[t]} !== 4'b0000 || lg_a[t] !== 6'd0) idle_bad++;
    check("post-reset idle", idle_bad, 0);

    // Independent decode of frame 1 from the line waveform.
    for (int t = 2; t <= FRAME_LEN; t++)
      if (lg_d[t] === 1'b1 && lg_d[t-1] === 1'b0) rises.push_back(t);
    check("rising edge count", rises.size(), 1536);
    check("first rising edge", (rises.size() > 0) ? rises[0] : 0, 3);
    gap_bad = 0;
    for (int i = 1; i < rises.size(); i++)
      if (rises[i] - rises[i-1] != BIT_CYC) gap_bad++;
    check("edge spacing", gap_bad, 0);

    w_bad = 0; hand_bad = 0; word_bad = 0; word = 24'd0;
    for (int i = 0; i < rises.size(); i++) begin
      w = 0;
      while (rises[i] + w <= LOGN && w < BIT_CYC && lg_d[rises[i] + w] === 1'b1) w++;
      if (w != T1H_CYC && w != T0H_CYC) w_bad++;
      if (i < 48) begin
        exp_w = (i == 0 || i == 23) ? T1H_CYC : T0H_CYC;
        if (w != exp_w) hand_bad++;
      end
      word = {word[22:0], (w == T1H_CYC)};
      if (i % 24 == 23 && i / 24 < NUM_PIXELS)
        if (word !== fb[i / 24]) word_bad++;
    end
    check("legal pulse widths", w_bad, 0);
    check("pixel0/1 pulse widths", hand_bad, 0);
    check("decoded words", word_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
